// File: rtl/mips_io_pkg.sv
// Shared encodings and status-word layout for the multi-channel MIPS I/O bridge.
package mips_io_pkg;

   typedef enum logic {
      SEL_DATA = 1'b0,
      SEL_STAT = 1'b1
   } sel_e;

   // Status word layout: {pad, to_flag, wr_err, rd_err, out_full[N-1:0], in_full[N-1:0]}
   localparam int IN_FULL_LSB = 0;

   function automatic int out_full_lsb(int nch);
      return nch;
   endfunction

   function automatic int rd_err_bit(int nch);
      return 2 * nch;
   endfunction

   function automatic int wr_err_bit(int nch);
      return 2 * nch + 1;
   endfunction

   function automatic int to_flag_bit(int nch);
      return 2 * nch + 2;
   endfunction

   // The status word must hold both full vectors plus the three flags.
   function automatic bit status_fits(int bw, int nch);
      return (nch >= 1) && ((2 * nch + 3) <= bw);
   endfunction

endpackage

// File: rtl/mips_io_chan.sv
// One bridge channel: a one-entry input buffer and a one-entry output buffer,
// each behind a valid/ready handshake. The core side pops/loads via strobes
// decoded in the top level.
module mips_io_chan #(
   parameter int BW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid_i,
   input  logic [BW-1:0] in_data_i,
   output logic          in_ready_o,
   output logic          in_full_o,
   output logic [BW-1:0] in_word_o,
   input  logic          pop_i,
   input  logic          load_i,
   input  logic [BW-1:0] wdata_i,
   input  logic          out_ready_i,
   output logic          out_valid_o,
   output logic [BW-1:0] out_data_o
);

   logic          in_full_q, in_full_d;
   logic [BW-1:0] in_q, in_d;
   logic          out_full_q, out_full_d;
   logic [BW-1:0] out_q, out_d;

   // Buffer next state: push only into an empty input buffer, so push and pop never coincide.
   // A load on a full output buffer is only issued when it drains in the same cycle.
   always_comb begin
      in_full_d  = in_full_q;
      in_d       = in_q;
      out_full_d = out_full_q;
      out_d      = out_q;
      if (in_valid_i && !in_full_q) begin
         in_full_d = 1'b1;
         in_d      = in_data_i;
      end else if (pop_i) begin
         in_full_d = 1'b0;
      end
      if (load_i) begin
         out_full_d = 1'b1;
         out_d      = wdata_i;
      end else if (out_full_q && out_ready_i) begin
         out_full_d = 1'b0;
      end
   end

   // Buffer registers, cleared (data included) by the asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_full_q  <= 1'b0;
         in_q       <= '0;
         out_full_q <= 1'b0;
         out_q      <= '0;
      end else begin
         in_full_q  <= in_full_d;
         in_q       <= in_d;
         out_full_q <= out_full_d;
         out_q      <= out_d;
      end
   end

   assign in_ready_o  = ~in_full_q;
   assign in_full_o   = in_full_q;
   assign in_word_o   = in_q;
   assign out_valid_o = out_full_q;
   assign out_data_o  = out_q;

endmodule

// File: rtl/mips_io_bridge.sv
// Multi-channel I/O bridge for the 16-bit MIPS core: address decode, read mux,
// stall generation with a timeout watchdog, and sticky read-to-clear error flags.
module mips_io_bridge
   import mips_io_pkg::*;
#(
   parameter int BUS_WIDTH     = 16,
   parameter int NUM_CH        = 4,
   parameter int BLOCKING      = 1,
   parameter int STALL_TIMEOUT = 255,
   parameter int AW            = $clog2(NUM_CH) + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AW-1:0]               io_addr,
   input  logic                        io_rd,
   input  logic                        io_wr,
   input  logic [BUS_WIDTH-1:0]        io_wdata,
   output logic [BUS_WIDTH-1:0]        io_rdata,
   output logic                        io_stall,
   input  logic [NUM_CH*BUS_WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]           in_valid,
   output logic [NUM_CH-1:0]           in_ready,
   output logic [NUM_CH*BUS_WIDTH-1:0] out_data,
   output logic [NUM_CH-1:0]           out_valid,
   input  logic [NUM_CH-1:0]           out_ready
);

   if (!status_fits(BUS_WIDTH, NUM_CH)) begin : g_bad_cfg
      $error("mips_io_bridge: NUM_CH=%0d needs 2*NUM_CH+3 status bits, BUS_WIDTH=%0d",
             NUM_CH, BUS_WIDTH);
   end

   localparam int   OF_LSB = out_full_lsb(NUM_CH);
   localparam int   RD_BIT = rd_err_bit(NUM_CH);
   localparam int   WR_BIT = wr_err_bit(NUM_CH);
   localparam int   TO_BIT = to_flag_bit(NUM_CH);
   localparam logic BLK    = (BLOCKING != 0);
   localparam int   CW     = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(STALL_TIMEOUT);

   sel_e                        sel;
   int                          ch_idx;
   logic [NUM_CH-1:0]           ch_sel;
   logic                        ch_ok;
   logic [NUM_CH-1:0]           in_full;
   logic [NUM_CH*BUS_WIDTH-1:0] in_q;
   logic [BUS_WIDTH-1:0]        in_word;
   logic [BUS_WIDTH-1:0]        status_word;
   logic                        in_full_sel, out_full_sel, out_ready_sel;
   logic                        rd_data, wr_data, stat_rd;
   logic                        rd_empty, wr_blocked, block_req, expire, force_fail;
   logic                        rd_fail, wr_fail, to_evt;
   logic [NUM_CH-1:0]           pop, load;
   logic                        rd_err_q, rd_err_d;
   logic                        wr_err_q, wr_err_d;
   logic                        to_flag_q, to_flag_d;
   logic [CW-1:0]               stall_cnt_q, stall_cnt_d;

   // Channel index is the address without the sel bit; integer modulo keeps NUM_CH=1 legal.
   assign sel    = sel_e'(io_addr[AW-1]);
   assign ch_idx = int'(io_addr) % (1 << (AW - 1));

   // One-hot channel select plus the selected channel's state; empty for out-of-range indices.
   always_comb begin
      ch_sel        = '0;
      in_word       = '0;
      in_full_sel   = 1'b0;
      out_full_sel  = 1'b0;
      out_ready_sel = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_idx == c) begin
            ch_sel[c]     = 1'b1;
            in_word       = in_q[c*BUS_WIDTH +: BUS_WIDTH];
            in_full_sel   = in_full[c];
            out_full_sel  = out_valid[c];
            out_ready_sel = out_ready[c];
         end
      end
   end

   assign ch_ok   = |ch_sel;
   assign rd_data = io_rd & (sel == SEL_DATA) & ch_ok;
   assign wr_data = io_wr & (sel == SEL_DATA) & ch_ok;
   assign stat_rd = io_rd & (sel == SEL_STAT);

   // Stall/watchdog: once the counter reaches the timeout the access completes as a failure.
   assign rd_empty   = rd_data & ~in_full_sel;
   assign wr_blocked = wr_data & out_full_sel & ~out_ready_sel;
   assign block_req  = BLK & (rd_empty | wr_blocked);
   assign expire     = (STALL_TIMEOUT != 0) && (stall_cnt_q == TO_VAL);
   assign io_stall   = rst & block_req & ~expire;
   assign force_fail = ~BLK | expire;
   assign rd_fail    = rd_empty & force_fail;
   assign wr_fail    = wr_blocked & force_fail;
   assign to_evt     = block_req & expire;

   assign pop  = ch_sel & {NUM_CH{rd_data & in_full_sel}};
   assign load = ch_sel & {NUM_CH{wr_data & (~out_full_sel | out_ready_sel)}};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      mips_io_chan #(
         .BW(BUS_WIDTH)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .in_valid_i  (in_valid[c]),
         .in_data_i   (in_data[c*BUS_WIDTH +: BUS_WIDTH]),
         .in_ready_o  (in_ready[c]),
         .in_full_o   (in_full[c]),
         .in_word_o   (in_q[c*BUS_WIDTH +: BUS_WIDTH]),
         .pop_i       (pop[c]),
         .load_i      (load[c]),
         .wdata_i     (io_wdata),
         .out_ready_i (out_ready[c]),
         .out_valid_o (out_valid[c]),
         .out_data_o  (out_data[c*BUS_WIDTH +: BUS_WIDTH])
      );
   end

   // Status word assembly.
   always_comb begin
      status_word                          = '0;
      status_word[IN_FULL_LSB +: NUM_CH]   = in_full;
      status_word[OF_LSB +: NUM_CH]        = out_valid;
      status_word[RD_BIT]                  = rd_err_q;
      status_word[WR_BIT]                  = wr_err_q;
      status_word[TO_BIT]                  = to_flag_q;
   end

   // Read mux: an empty or stalled data read returns zero.
   always_comb begin
      io_rdata = '0;
      if (stat_rd) begin
         io_rdata = status_word;
      end else if (rd_data && in_full_sel) begin
         io_rdata = in_word;
      end
   end

   // Flag and counter next state: a same-cycle error event wins over the clearing status read.
   always_comb begin
      rd_err_d    = (rd_err_q & ~stat_rd) | rd_fail;
      wr_err_d    = (wr_err_q & ~stat_rd) | wr_fail;
      to_flag_d   = (to_flag_q & ~stat_rd) | to_evt;
      stall_cnt_d = io_stall ? stall_cnt_q + 1'b1 : '0;
   end

   // Flag and watchdog registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_err_q    <= 1'b0;
         wr_err_q    <= 1'b0;
         to_flag_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         rd_err_q    <= rd_err_d;
         wr_err_q    <= wr_err_d;
         to_flag_q   <= to_flag_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_mips_io_bridge.sv
// Bench for mips_io_bridge: three configurations share one stimulus stream
// (blocking/255, non-blocking/255, blocking/4). A per-instance behavioural model
// is compared every cycle, plus hand-computed literal expectations.
module tb_mips_io_bridge;

   localparam int BW = 16;
   localparam int NC = 4;
   localparam int NI = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [2:0]     io_addr;
   logic           io_rd, io_wr;
   logic [BW-1:0]  io_wdata;
   logic [NC*BW-1:0] in_data;
   logic [NC-1:0]  in_valid, out_ready;

   logic [BW-1:0]    rdata     [NI];
   logic             stall     [NI];
   logic [NC-1:0]    in_ready  [NI];
   logic [NC-1:0]    out_valid [NI];
   logic [NC*BW-1:0] out_data  [NI];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   function automatic bit blk_of(int k);
      return k != 1;
   endfunction

   function automatic int tmo_of(int k);
      return (k == 2) ? 4 : 255;
   endfunction

   for (genvar k = 0; k < NI; k++) begin : g_dut
      mips_io_bridge #(
         .BUS_WIDTH     (BW),
         .NUM_CH        (NC),
         .BLOCKING      ((k == 1) ? 0 : 1),
         .STALL_TIMEOUT ((k == 2) ? 4 : 255)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .io_addr   (io_addr),
         .io_rd     (io_rd),
         .io_wr     (io_wr),
         .io_wdata  (io_wdata),
         .io_rdata  (rdata[k]),
         .io_stall  (stall[k]),
         .in_data   (in_data),
         .in_valid  (in_valid),
         .in_ready  (in_ready[k]),
         .out_data  (out_data[k]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready)
      );
   end

   task automatic check(input string name, input int k, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s inst%0d actual=%0h required=%0h", name, k, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   bit          m_inf [NI][NC];
   logic [15:0] m_inb [NI][NC];
   bit          m_of  [NI][NC];
   logic [15:0] m_ob  [NI][NC];
   bit          m_rde [NI];
   bit          m_wre [NI];
   bit          m_tof [NI];
   int          m_cnt [NI];

   always @(negedge clk) begin : model_cmp
      int          ch;
      bit          sel, rd_wait, wr_wait, want_block, expired, e_stall, do_pop, do_load;
      logic [15:0] e_rdata, stat;
      logic [3:0]  e_rdy, e_ov;
      logic [63:0] e_od;
      for (int k = 0; k < NI; k++) begin
         if (!rst) begin
            for (int c = 0; c < NC; c++) begin
               m_inf[k][c] = 0; m_inb[k][c] = '0; m_of[k][c] = 0; m_ob[k][c] = '0;
            end
            m_rde[k] = 0; m_wre[k] = 0; m_tof[k] = 0; m_cnt[k] = 0;
         end
         sel = io_addr[2];
         ch  = int'(io_addr[1:0]);
         stat = '0;
         for (int c = 0; c < NC; c++) begin
            if (m_inf[k][c]) stat = stat | 16'(1 << c);
            if (m_of[k][c])  stat = stat | 16'(1 << (NC + c));
         end
         if (m_rde[k]) stat = stat | 16'h0100;
         if (m_wre[k]) stat = stat | 16'h0200;
         if (m_tof[k]) stat = stat | 16'h0400;
         e_rdata = '0;
         if (io_rd) e_rdata = sel ? stat : (m_inf[k][ch] ? m_inb[k][ch] : 16'h0);
         rd_wait    = io_rd && !sel && !m_inf[k][ch];
         wr_wait    = io_wr && !sel && m_of[k][ch] && !out_ready[ch];
         want_block = blk_of(k) && (rd_wait || wr_wait);
         expired    = (tmo_of(k) > 0) && (m_cnt[k] == tmo_of(k));
         e_stall    = rst && want_block && !expired;
         for (int c = 0; c < NC; c++) begin
            e_rdy[c] = !m_inf[k][c];
            e_ov[c]  = m_of[k][c];
            e_od[c*16 +: 16] = m_ob[k][c];
         end
         check("m_rdata", k, rdata[k], e_rdata);
         check("m_stall", k, stall[k], e_stall);
         check("m_in_ready", k, in_ready[k], e_rdy);
         check("m_out_valid", k, out_valid[k], e_ov);
         check("m_out_data", k, out_data[k], e_od);
         if (rst) begin
            do_pop  = io_rd && !sel && m_inf[k][ch];
            do_load = io_wr && !sel && (!m_of[k][ch] || out_ready[ch]);
            if (io_rd && sel) begin
               m_rde[k] = 0; m_wre[k] = 0; m_tof[k] = 0;
            end
            if (rd_wait && (!blk_of(k) || expired)) m_rde[k] = 1;
            if (wr_wait && (!blk_of(k) || expired)) m_wre[k] = 1;
            if (want_block && expired) m_tof[k] = 1;
            m_cnt[k] = e_stall ? m_cnt[k] + 1 : 0;
            for (int c = 0; c < NC; c++) begin
               if (in_valid[c] && !m_inf[k][c]) begin
                  m_inf[k][c] = 1;
                  m_inb[k][c] = in_data[c*16 +: 16];
               end
            end
            if (do_pop) m_inf[k][ch] = 0;
            for (int c = 0; c < NC; c++)
               if (m_of[k][c] && out_ready[c]) m_of[k][c] = 0;
            if (do_load) begin
               m_of[k][ch] = 1;
               m_ob[k][ch] = io_wdata;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic next();
      @(posedge clk);
      #1;
      io_rd    = 1'b0;
      io_wr    = 1'b0;
      in_valid = '0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin : stim
      int n0, n2;
      rst = 1'b0; io_addr = '0; io_rd = 0; io_wr = 0; io_wdata = '0;
      in_data = '0; in_valid = '0; out_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 0, in_ready[0], 4'hF);
      check("rst_out_valid", 0, out_valid[0], 4'h0);
      check("rst_stall", 0, stall[0], 1'b0);
      next(); rst = 1'b1;

      // ch2 push then read
      next(); in_valid = 4'b0100; in_data[2*16 +: 16] = 16'h1234;
      settle(); check("s1_ready_push", 0, in_ready[0], 4'hF);
      next(); io_rd = 1; io_addr = 3'b010;
      settle();
      check("s1_rdata", 0, rdata[0], 16'h1234);
      check("s1_stall", 0, stall[0], 1'b0);
      check("s1_ready_full", 0, in_ready[0], 4'b1011);
      next(); settle(); check("s1_ready_back", 0, in_ready[0], 4'hF);

      // blocked read of ch1, data arrives in the 5th stall cycle
      n0 = 0; n2 = 0;
      for (int i = 0; i < 5; i++) begin
         next(); io_rd = 1; io_addr = 3'b001;
         if (i == 4) begin in_valid = 4'b0010; in_data[16 +: 16] = 16'hBEEF; end
         settle(); n0 += int'(stall[0]); n2 += int'(stall[2]);
      end
      next(); io_rd = 1; io_addr = 3'b001;
      settle();
      check("s2_stall_cycles", 0, n0, 5);
      check("s2_stall_cycles_to4", 2, n2, 4);
      check("s2_rdata", 0, rdata[0], 16'hBEEF);
      check("s2_stall_done", 0, stall[0], 1'b0);
      check("s2_rdata_nb", 1, rdata[1], 16'hBEEF);
      next(); io_rd = 1; io_addr = 3'b100;
      settle();
      check("s2_stat", 0, rdata[0], 16'h0000);
      check("s2_stat", 1, rdata[1], 16'h0100);
      check("s2_stat", 2, rdata[2], 16'h0500);
      next(); settle();

      // output buffer: fill, blocked refill, drain+refill on the same edge
      next(); io_wr = 1; io_addr = 3'b000; io_wdata = 16'hA5A5;
      settle(); check("s3_first_wr_stall", 0, stall[0], 1'b0);
      for (int i = 0; i < 3; i++) begin
         next(); io_wr = 1; io_wdata = 16'h5A5A;
         settle(); check("s3_held_stall", 0, stall[0], 1'b1);
      end
      next(); io_wr = 1; io_wdata = 16'h5A5A; out_ready = 4'b0001;
      settle();
      check("s3_accept_stall", 0, stall[0], 1'b0);
      check("s3_drain_data", 0, out_data[0][15:0], 16'hA5A5);
      next(); out_ready = 4'b0000;
      settle();
      check("s3_refill_data", 0, out_data[0][15:0], 16'h5A5A);
      check("s3_refill_valid", 0, out_valid[0], 4'b0001);
      next(); out_ready = 4'b0001; settle();
      next(); out_ready = 4'b0000;
      settle(); check("s3_drained", 0, out_valid[0], 4'b0000);
      next(); io_rd = 1; io_addr = 3'b100;
      settle();
      check("s3_stat", 1, rdata[1], 16'h0200);
      check("s3_stat", 0, rdata[0], 16'h0000);

      // non-blocking empty read and read-to-clear
      next(); io_rd = 1; io_addr = 3'b011;
      settle();
      check("s4_rdata", 1, rdata[1], 16'h0000);
      check("s4_stall", 1, stall[1], 1'b0);
      check("s4_stall_blk", 0, stall[0], 1'b1);
      next(); io_rd = 1; io_addr = 3'b100;
      settle(); check("s4_stat1", 1, rdata[1], 16'h0100);
      next(); io_rd = 1; io_addr = 3'b100;
      settle(); check("s4_stat2", 1, rdata[1], 16'h0000);

      // watchdog release on a write to a full buffer
      next(); io_wr = 1; io_addr = 3'b000; io_wdata = 16'h1111; settle();
      n2 = 0;
      for (int i = 0; i < 5; i++) begin
         next(); io_wr = 1; io_wdata = 16'h2222;
         settle(); n2 += int'(stall[2]);
         if (i == 4) check("s5_release", 2, stall[2], 1'b0);
      end
      check("s5_stall_cycles", 2, n2, 4);
      next(); io_rd = 1; io_addr = 3'b100;
      settle();
      check("s5_stat", 2, rdata[2], 16'h0610);
      check("s5_stat", 0, rdata[0], 16'h0010);
      check("s5_stat", 1, rdata[1], 16'h0210);
      check("s5_out_data", 2, out_data[2][15:0], 16'h1111);

      // fill everything, stall, then asynchronous reset mid-cycle
      next(); in_valid = 4'hF; in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      next(); io_wr = 1; io_addr = 3'b001; io_wdata = 16'hC001;
      next(); io_wr = 1; io_addr = 3'b010; io_wdata = 16'hC002;
      next(); io_wr = 1; io_addr = 3'b011; io_wdata = 16'hC003;
      next(); io_wr = 1; io_addr = 3'b000; io_wdata = 16'hDEAD;
      settle();
      check("s6_stall", 0, stall[0], 1'b1);
      check("s6_out_valid", 0, out_valid[0], 4'hF);
      check("s6_in_ready", 0, in_ready[0], 4'h0);
      #2; rst = 1'b0; #1;
      for (int k = 0; k < NI; k++) begin
         check("s6_rst_stall", k, stall[k], 1'b0);
         check("s6_rst_out_valid", k, out_valid[k], 4'h0);
         check("s6_rst_in_ready", k, in_ready[k], 4'hF);
         check("s6_rst_out_data", k, out_data[k], 64'h0);
      end
      next(); next(); rst = 1'b1;
      next(); settle();
      check("end_in_ready", 0, in_ready[0], 4'hF);
      next(); settle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
